// File: rtl/ex_muldiv_if.sv
// Multiply/divide unit bus: EX-stage launch, MTHI/MTLO writes, HI/LO results.
// master drives start/op/operands/writes/flush; slave returns hi/lo/busy/done.
interface ex_muldiv_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A_in;
  logic [31:0] B_in;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        flush;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  modport master (
    output start, op, A_in, B_in,
    output hi_we, lo_we, wdata, flush,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, A_in, B_in,
    input  hi_we, lo_we, wdata, flush,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative 32-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Ports: clk, reset (sync, active-high), bus (ex_muldiv_if.slave).
module ex_muldiv (
  input  logic        clk,
  input  logic        reset,
  ex_muldiv_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic        is_div;
  logic        neg_res;
  logic        neg_rem;
  logic        div0;
  logic [31:0] acc;
  logic [31:0] lo_acc;
  logic [31:0] opnd;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        done_q;

  logic        sgn_in;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        accept;
  logic        last;

  logic [32:0] sum;
  logic [32:0] shl;
  logic [32:0] trial;
  logic [31:0] acc_nxt;
  logic [31:0] lo_nxt;
  logic [63:0] prod;
  logic [63:0] prod_s;
  logic [31:0] quo;
  logic [31:0] rem;

  assign sgn_in = ~bus.op[0];
  assign a_neg  = sgn_in & bus.A_in[31];
  assign b_neg  = sgn_in & bus.B_in[31];
  assign a_mag  = a_neg ? -bus.A_in : bus.A_in;
  assign b_mag  = b_neg ? -bus.B_in : bus.B_in;

  assign accept = (state == IDLE) & bus.start & ~bus.flush;
  assign last   = (state == RUN) & (cnt == 5'd31) & ~bus.flush;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN:  if (bus.flush || cnt == 5'd31) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Multiply: {acc,lo_acc} holds partial product / remaining multiplier.
  // Divide: acc is the partial remainder, lo_acc shifts dividend out
  // and quotient bits in. A zero divisor naturally yields all-ones.
  always_comb begin
    sum   = {1'b0, acc} + (lo_acc[0] ? {1'b0, opnd} : 33'd0);
    shl   = {acc, lo_acc[31]};
    trial = shl - {1'b0, opnd};
    if (is_div) begin
      if (!trial[32]) begin
        acc_nxt = trial[31:0];
        lo_nxt  = {lo_acc[30:0], 1'b1};
      end else begin
        acc_nxt = shl[31:0];
        lo_nxt  = {lo_acc[30:0], 1'b0};
      end
    end else begin
      acc_nxt = sum[32:1];
      lo_nxt  = {sum[0], lo_acc[31:1]};
    end
  end

  always_comb begin
    prod   = {acc_nxt, lo_nxt};
    prod_s = neg_res ? -prod : prod;
    quo    = neg_res ? -lo_nxt : lo_nxt;
    rem    = neg_rem ? -acc_nxt : acc_nxt;
    if (div0) quo = 32'hFFFF_FFFF;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= 5'd0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      acc     <= 32'd0;
      lo_acc  <= 32'd0;
      opnd    <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      done_q <= last;
      if (state == IDLE) begin
        if (accept) begin
          cnt     <= 5'd0;
          is_div  <= bus.op[1];
          neg_res <= a_neg ^ b_neg;
          neg_rem <= a_neg;
          div0    <= bus.op[1] & (bus.B_in == 32'd0);
          acc     <= 32'd0;
          lo_acc  <= a_mag;
          opnd    <= b_mag;
        end else if (!bus.start) begin
          if (bus.hi_we) hi_q <= bus.wdata;
          if (bus.lo_we) lo_q <= bus.wdata;
        end
      end else if (!bus.flush) begin
        acc    <= acc_nxt;
        lo_acc <= lo_nxt;
        cnt    <= cnt + 5'd1;
        if (cnt == 5'd31) begin
          if (is_div) begin
            hi_q <= rem;
            lo_q <= quo;
          end else begin
            hi_q <= prod_s[63:32];
            lo_q <= prod_s[31:0];
          end
        end
      end
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = (state == RUN);
  assign bus.done = done_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: random and directed ops vs arithmetic model.
// Checks latency, flush/reset aborts, MTHI/MTLO and start priority.
module tb_ex_muldiv;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  logic [63:0] exp_q[$];

  ex_muldiv_if bus();

  ex_muldiv dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, p;
    int     q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'd0: begin
        p = sa * sb;
        return p;
      end
      2'd1: return {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return {32'd0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  always @(negedge clk) begin
    if (!reset && bus.done) begin
      check("done_busy_overlap", {63'd0, bus.busy}, 64'd0);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got hi=%h lo=%h want no done",
                 bus.hi, bus.lo);
      end else begin
        check("result", {bus.hi, bus.lo}, exp_q.pop_front());
      end
    end
  end

  task automatic launch(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit push,
                        input logic lo_we);
    bus.start = 1'b1;
    bus.op    = op;
    bus.A_in  = a;
    bus.B_in  = b;
    bus.lo_we = lo_we;
    if (push) exp_q.push_back(model(op, a, b));
    @(negedge clk);
    bus.start = 1'b0;
    bus.lo_we = 1'b0;
    check("busy_after_start", {63'd0, bus.busy}, 64'd1);
  endtask

  task automatic wait_done(input int n0);
    int n = n0;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("latency", 64'(n), 64'd33);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    launch(op, a, b, 1'b1, 1'b0);
    wait_done(1);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] t[5];
    t = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(3) == 0) return t[$urandom_range(4)];
    return $urandom;
  endfunction

  initial begin
    logic [31:0] old_hi, old_lo;
    int k;
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'd0;
    bus.A_in  = 32'd0;
    bus.B_in  = 32'd0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = 32'd0;
    bus.flush = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_state", {bus.hi, bus.lo},
          64'd0);
    check("reset_flags", {62'd0, bus.busy, bus.done}, 64'd0);

    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(2'd0, 32'hFFFF_FFFD, 32'd7);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2);
    run_op(2'd3, 32'd100, 32'd0);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd0);
    @(negedge clk);

    bus.hi_we = 1'b1;
    bus.wdata = 32'h1234_5678;
    @(negedge clk);
    bus.hi_we = 1'b0;
    check("mthi", {32'd0, bus.hi}, {32'd0, 32'h1234_5678});
    bus.lo_we = 1'b1;
    bus.wdata = 32'h0BAD_F00D;
    @(negedge clk);
    bus.lo_we = 1'b0;
    check("mtlo", {32'd0, bus.lo}, {32'd0, 32'h0BAD_F00D});

    old_hi = bus.hi;
    old_lo = bus.lo;
    launch(2'd1, $urandom, $urandom, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy", {63'd0, bus.busy}, 64'd0);
    check("flush_hilo", {bus.hi, bus.lo}, {old_hi, old_lo});
    repeat (40) @(negedge clk);

    launch(2'd1, 32'd5, 32'd6, 1'b1, 1'b0);
    old_hi = bus.hi;
    bus.hi_we = 1'b1;
    bus.wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.hi_we = 1'b0;
    check("mthi_in_run", {32'd0, bus.hi}, {32'd0, old_hi});
    wait_done(2);
    @(negedge clk);

    old_lo = bus.lo;
    bus.wdata = 32'h1357_9BDF;
    launch(2'd3, 32'd9, 32'd3, 1'b0, 1'b1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("start_beats_mtlo", {32'd0, bus.lo}, {32'd0, old_lo});

    bus.flush = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    bus.start = 1'b0;
    check("flush_blocks_start", {63'd0, bus.busy}, 64'd0);

    launch(2'd2, $urandom, $urandom, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_run_hilo", {bus.hi, bus.lo}, 64'd0);
    check("reset_run_busy", {63'd0, bus.busy}, 64'd0);
    run_op(2'd2, 32'hFFFF_FF9C, 32'd7);

    for (int i = 0; i < 30; i++) begin
      run_op(2'($urandom_range(3)), pick(), pick());
      if ($urandom_range(1) == 1) @(negedge clk);
    end

    repeat (40) @(negedge clk);
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
